// File: rtl/reg_model_pkg.sv
// Shared types for the register-model bank: access codes, FSM states, field widths.
package reg_model_pkg;

   localparam int ACC_W  = 2;
   localparam int SIZE_W = 6;

   typedef enum logic [ACC_W-1:0] {
      ACC_RO  = 2'd0,
      ACC_RW  = 2'd1,
      ACC_WO  = 2'd2,
      ACC_W1C = 2'd3
   } access_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/reg_access_apply.sv
// Applies one register access to a stored value: produces the updated value,
// the read data returned to the requester and the error flag.
module reg_access_apply
   import reg_model_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] value,
   input  logic [DATA_W-1:0] mask,
   input  access_e           access,
   input  logic              write,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] new_value,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   // Access semantics: writes never return data, WO never reads back, RO rejects writes
   always_comb begin
      new_value = value;
      rdata     = '0;
      err       = 1'b0;
      if (write) begin
         case (access)
            ACC_RW,
            ACC_WO:  new_value = wdata & mask;
            ACC_W1C: new_value = value & ~(wdata & mask);
            default: err = 1'b1;
         endcase
      end else begin
         case (access)
            ACC_WO:  rdata = '0;
            default: rdata = value;
         endcase
      end
   end

endmodule

// File: rtl/reg_model_bank.sv
// Register-model bank: a loadable table of register descriptors searched
// linearly (one entry per cycle) to service read/write accesses by offset.
module reg_model_bank
   import reg_model_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          ld_valid_i,
   output logic                          ld_ready_o,
   input  logic [ADDR_W-1:0]             ld_offset_i,
   input  logic [SIZE_W-1:0]             ld_size_i,
   input  logic [ACC_W-1:0]              ld_access_i,
   input  logic [DATA_W-1:0]             ld_reset_i,
   output logic [$clog2(NUM_REGS+1)-1:0] ld_count_o,
   input  logic                          clear_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_write_i,
   input  logic [ADDR_W-1:0]             req_addr_i,
   input  logic [DATA_W-1:0]             req_wdata_i,
   output logic                          rsp_valid_o,
   input  logic                          rsp_ready_i,
   output logic [DATA_W-1:0]             rsp_rdata_o,
   output logic                          rsp_err_o,
   output logic                          busy_o
);

   localparam int CNT_W = $clog2(NUM_REGS+1);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_REGS);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   // Descriptor table; contents past ld_count_o are never looked at, so no reset
   logic [ADDR_W-1:0] ent_off  [NUM_REGS];
   access_e           ent_acc  [NUM_REGS];
   logic [DATA_W-1:0] ent_mask [NUM_REGS];
   logic [DATA_W-1:0] ent_val  [NUM_REGS];

   state_e            state;
   logic [IDX_W-1:0]  idx;
   logic              q_write;
   logic [ADDR_W-1:0] q_addr;
   logic [DATA_W-1:0] q_wdata;

   logic              ld_fire, req_fire, in_range, last, hit;
   logic [DATA_W-1:0] ld_mask, ap_new, ap_rdata;
   logic              ap_err;

   assign req_ready_o = (state == ST_IDLE) && !clear_i;
   assign ld_ready_o  = (state == ST_IDLE) && !req_valid_i && !clear_i && (ld_count_o < FULL);
   assign busy_o      = (state != ST_IDLE);
   assign ld_fire     = ld_valid_i && ld_ready_o;
   assign req_fire    = req_valid_i && req_ready_o;

   // Sizes at or beyond the data width keep every bit
   assign ld_mask = (int'(ld_size_i) >= DATA_W) ? '1
                                                : ((DATA_W'(1) << ld_size_i) - DATA_W'(1));

   // Scan terminates on the first matching entry or after the last loaded one
   assign in_range = CNT_W'(idx) < ld_count_o;
   assign last     = (CNT_W'(idx) + ONE) >= ld_count_o;
   assign hit      = (state == ST_SEARCH) && in_range && (ent_off[idx] == q_addr);

   reg_access_apply #(.DATA_W(DATA_W)) u_apply (
      .value     (ent_val[idx]),
      .mask      (ent_mask[idx]),
      .access    (ent_acc[idx]),
      .write     (q_write),
      .wdata     (q_wdata),
      .new_value (ap_new),
      .rdata     (ap_rdata),
      .err       (ap_err)
   );

   // Table storage: loads append at the current count, hits commit the updated value
   always_ff @(posedge clk_i) begin
      if (ld_fire) begin
         ent_off[ld_count_o[IDX_W-1:0]]  <= ld_offset_i;
         ent_acc[ld_count_o[IDX_W-1:0]]  <= access_e'(ld_access_i);
         ent_mask[ld_count_o[IDX_W-1:0]] <= ld_mask;
         ent_val[ld_count_o[IDX_W-1:0]]  <= ld_reset_i & ld_mask;
      end else if (hit) begin
         ent_val[idx] <= ap_new;
      end
   end

   // Control FSM with registered response outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         ld_count_o  <= '0;
         idx         <= '0;
         q_write     <= 1'b0;
         q_addr      <= '0;
         q_wdata     <= '0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_fire) begin
                  q_write <= req_write_i;
                  q_addr  <= req_addr_i;
                  q_wdata <= req_wdata_i;
                  idx     <= '0;
                  state   <= ST_SEARCH;
               end else if (clear_i) begin
                  ld_count_o <= '0;
               end else if (ld_fire) begin
                  ld_count_o <= ld_count_o + ONE;
               end
            end
            ST_SEARCH: begin
               if (hit) begin
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= ap_rdata;
                  rsp_err_o   <= ap_err;
                  state       <= ST_RESP;
               end else if (last) begin
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= '0;
                  rsp_err_o   <= 1'b1;
                  state       <= ST_RESP;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/reg_model_bank.md
REG_MODEL_BANK -- requirements
Module: reg_model_bank

Interface
REQ-001 Parameter NUM_REGS, 16, maximum number of register descriptors held.
REQ-002 Parameter ADDR_W, 32, width of register address offset.
REQ-003 Parameter DATA_W, 32, register data width; size field range 0..DATA_W.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 ld_valid_i / ld_ready_o  in/out  1/1  descriptor load handshake.
REQ-007 ld_offset_i  in  ADDR_W  register addressOffset.
REQ-008 ld_size_i  in  6  register size in bits.
REQ-009 ld_access_i  in  2  access code: RO=0, RW=1, WO=2, W1C=3.
REQ-010 ld_reset_i  in  DATA_W  register resetValue.
REQ-011 ld_count_o  out  $clog2(NUM_REGS+1)  number of descriptors loaded.
REQ-012 clear_i  in  1  empty the table.
REQ-013 req_valid_i / req_ready_o  in/out  1/1  access request handshake.
REQ-014 req_write_i, req_addr_i, req_wdata_i  in  1, ADDR_W, DATA_W  access direction, offset, write data.
REQ-015 rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
REQ-016 rsp_rdata_o, rsp_err_o  out  DATA_W, 1  read data, error flag.
REQ-017 busy_o  out  1  high whenever FSM is not IDLE.

Function
REQ-018 FSM states IDLE, SEARCH, RESP; IDLE->SEARCH on request accept, SEARCH->RESP on hit or scan end, RESP->IDLE on rsp_valid_o && rsp_ready_i.
REQ-019 req_ready_o = (state==IDLE) && !clear_i; request has priority over load.
REQ-020 ld_ready_o = (state==IDLE) && !req_valid_i && !clear_i && (ld_count_o < NUM_REGS); load blocked when full.
REQ-021 Load accept writes entry[ld_count_o] with offset, access, mask = (size>=DATA_W ? all-ones : (1<<size)-1), value = ld_reset_i & mask; ld_count_o increments next edge.
REQ-022 No duplicate-offset check on load; lookup returns the lowest-index match.
REQ-023 clear_i in IDLE sets ld_count_o to 0 next edge; ignored in SEARCH/RESP.
REQ-024 SEARCH compares one entry per cycle, index 0 upward; hit at index k -> rsp_valid_o high after edge k+1 counted from acceptance edge.
REQ-025 Miss -> rsp_valid_o high after edge max(ld_count_o,1); rsp_err_o=1, rsp_rdata_o=0, no state change.
REQ-026 Read hit: RO/RW/W1C return value, WO returns 0; rsp_err_o=0.
REQ-027 Write hit: RW value=wdata&mask; WO same; W1C value&=~(wdata&mask); RO unchanged with rsp_err_o=1; rsp_rdata_o=0.
REQ-028 Entry value update occurs on the SEARCH->RESP edge; a subsequent read observes it.
REQ-029 Offset match is exact equality; no partial/unaligned matching.
REQ-030 rsp_rdata_o, rsp_err_o stable while rsp_valid_o high and rsp_ready_i low.

Reset
REQ-031 On rst_ni low: state IDLE, ld_count_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, busy_o 0; ld_ready_o/req_ready_o follow REQ-019/020.
REQ-032 Entry storage is not reset; content beyond ld_count_o is don't-care.
REQ-033 Reset mid-SEARCH or mid-RESP aborts the access; no response issued after release.

Structure
REQ-034 Package reg_model_pkg holds access enum, FSM state enum, and width constants.
REQ-035 One sub-module reg_access_apply: combinational value/mask/access/wdata -> new value, rdata, err.

Verification
REQ-036 Load {0x0,32,RW,0xA5A5_0000}, read 0x0 -> rdata 0xA5A5_0000, err 0, rsp after 1 edge.
REQ-037 Load 4 descriptors (offsets 0x0,0x4,0x8,0xC; RO,RW,WO,W1C); read 0xC -> rsp after 4 edges; read 0x10 -> err 1 after 4 edges.
REQ-038 RO at 0x0 reset 0x1: write 0xFFFF_FFFF -> err 1; read -> 0x1.
REQ-039 W1C size 8 reset 0xFF: write 0x0000_010F -> read returns 0xF0; WO write 0x1234 then read -> 0, err 0.
REQ-040 Load NUM_REGS entries -> ld_ready_o low, ld_count_o=16; clear_i -> count 0; read any -> err 1 after 1 edge.
REQ-041 Hold rsp_ready_i low 5 cycles -> response stable; assert rst_ni low during SEARCH -> IDLE, no response.
